// File: rtl/mem_checker_if.sv
// Bus bundle between the memory checker and its surroundings (config, run control, memory read, results).
// The cfg_mask signal exists only when MEM_CHECKER_MASK_EN is defined.
interface mem_checker_if #(
  parameter int AW   = 15,
  parameter int DW   = 16,
  parameter int NCHK = 8,
  parameter int CW   = 16
);
  localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam int NW = $clog2(NCHK) + 1;

  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_exp;
`ifdef MEM_CHECKER_MASK_EN
  logic [DW-1:0] cfg_mask;
`endif
  logic [NW-1:0] cfg_num;
  logic [CW-1:0] run_cycles;
  logic          start;
  logic          cpu_hold;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [NW-1:0] err_count;
  logic [IW-1:0] first_err_idx;
  logic [DW-1:0] first_err_actual;

  modport slave (
    input  cfg_we,
`ifdef MEM_CHECKER_MASK_EN
    input  cfg_mask,
`endif
    input  cfg_idx, cfg_addr, cfg_exp, cfg_num, run_cycles, start, rd_data,
    output cpu_hold, rd_addr, busy, done, pass, err_count, first_err_idx, first_err_actual
  );

  modport master (
    output cfg_we,
`ifdef MEM_CHECKER_MASK_EN
    output cfg_mask,
`endif
    output cfg_idx, cfg_addr, cfg_exp, cfg_num, run_cycles, start, rd_data,
    input  cpu_hold, rd_addr, busy, done, pass, err_count, first_err_idx, first_err_actual
  );
endinterface

// File: rtl/mem_checker.sv
// Lets the CPU run for a programmed number of cycles, freezes it, then checks a table of
// memory words against expected values. MEM_CHECKER_MASK_EN adds a per-entry compare mask.
module mem_checker #(
  parameter int AW   = 15,
  parameter int DW   = 16,
  parameter int NCHK = 8,
  parameter int CW   = 16
) (
  input logic          clk,
  input logic          reset_n,
  mem_checker_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start; cpu_hold stays set after a completed run
  // RUN   | CPU running, cycle counter counting down
  // HOLD  | CPU frozen one cycle so an in-flight write retires
  // READ  | rd_addr presents the current table entry address
  // CMP   | rd_data compared against the expected value
  // DONE  | one-cycle done pulse, pass valid

  localparam int IW = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam int NW = $clog2(NCHK) + 1;

  typedef enum logic [2:0] {IDLE, RUN, HOLD, READ, CMP, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NW-1:0] num_q, num_d;
  logic [NW-1:0] err_q, err_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [DW-1:0] fact_q, fact_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          pass_q, pass_d;
  logic          hold_q, hold_d;

  logic [AW-1:0] tbl_addr_q [NCHK];
  logic [DW-1:0] tbl_exp_q  [NCHK];
  logic [DW-1:0] cmp_mask;
  logic [NW-1:0] cfg_num_sat;
  logic          mismatch;
  logic          last_idx;

`ifdef MEM_CHECKER_MASK_EN
  logic [DW-1:0] tbl_mask_q [NCHK];

  always_ff @(posedge clk) begin
    if (bus.cfg_we) tbl_mask_q[bus.cfg_idx] <= bus.cfg_mask;
  end

  assign cmp_mask = tbl_mask_q[idx_q];
`else
  assign cmp_mask = '1;
`endif

  // Table has no reset: contents survive reset_n and are undefined until written.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      tbl_addr_q[bus.cfg_idx] <= bus.cfg_addr;
      tbl_exp_q[bus.cfg_idx]  <= bus.cfg_exp;
    end
  end

  assign cfg_num_sat = (bus.cfg_num > NW'(NCHK)) ? NW'(NCHK) : bus.cfg_num;
  assign mismatch    = |((bus.rd_data ^ tbl_exp_q[idx_q]) & cmp_mask);
  assign last_idx    = (NW'(idx_q) + NW'(1)) == num_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    num_d     = num_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    fact_d    = fact_q;
    rd_addr_d = rd_addr_q;
    pass_d    = pass_q;
    hold_d    = hold_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = bus.run_cycles;
          num_d   = cfg_num_sat;
          err_d   = '0;
          fidx_d  = '0;
          fact_d  = '0;
          pass_d  = 1'b0;
          hold_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          hold_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        idx_d = '0;
        if (num_q == '0) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        rd_addr_d = tbl_addr_q[idx_q];
        state_d   = CMP;
      end
      CMP: begin
        if (mismatch) begin
          err_d = err_q + NW'(1);
          if (err_q == '0) begin
            fidx_d = idx_q;
            fact_d = bus.rd_data;
          end
        end
        if (last_idx) begin
          state_d = DONE;
          pass_d  = !mismatch && (err_q == '0);
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      num_q     <= '0;
      err_q     <= '0;
      fidx_q    <= '0;
      fact_q    <= '0;
      rd_addr_q <= '0;
      pass_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      fact_q    <= fact_d;
      rd_addr_q <= rd_addr_d;
      pass_q    <= pass_d;
      hold_q    <= hold_d;
    end
  end

  // Combinational in READ so a table write landing just before the read is still seen.
  assign bus.rd_addr          = (state_q == READ) ? tbl_addr_q[idx_q] : rd_addr_q;
  assign bus.busy             = (state_q == RUN) || (state_q == HOLD) ||
                                (state_q == READ) || (state_q == CMP);
  assign bus.done             = (state_q == DONE);
  assign bus.cpu_hold         = hold_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_err_idx    = fidx_q;
  assign bus.first_err_actual = fact_q;
endmodule

// File: doc/mem_checker.md
MEM_CHECKER -- requirements
Module: mem_checker

Interface
REQ-001 SHALL have parameter AW, default 15, data-memory address width.
REQ-002 SHALL have parameter DW, default 16, data-memory word width.
REQ-003 SHALL have parameter NCHK, default 8, check-table depth (entries; 1..64).
REQ-004 SHALL have parameter CW, default 16, run-cycle counter width.
REQ-005 SHALL have ports (single clock; reset asynchronous, active-low):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  check-table write strobe
- cfg_idx  in  clog2(NCHK)  table entry index
- cfg_addr  in  AW  address to check
- cfg_exp  in  DW  expected value
- cfg_mask  in  DW  compare mask (present only with MEM_CHECKER_MASK_EN)
- cfg_num  in  clog2(NCHK)+1  number of active entries
- run_cycles  in  CW  cycles the CPU runs before checking
- start  in  1  one-cycle start pulse
- cpu_hold  out  1  freezes CPU/ROM fetch (drives stall)
- rd_addr  out  AW  memory read address
- rd_data  in  DW  memory read data, valid one cycle after rd_addr
- busy  out  1  run or check in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  all checks matched (valid from done until next start)
- err_count  out  clog2(NCHK)+1  number of mismatches
- first_err_idx  out  clog2(NCHK)  index of first mismatch
- first_err_actual  out  DW  value read at first mismatch

Function
REQ-006 SHALL implement FSM states IDLE, RUN, HOLD, READ, CMP, DONE.
REQ-007 IDLE: start=1 SHALL latch run_cycles and cfg_num, clear err_count/pass/first_err_*, go to RUN next cycle.
REQ-008 RUN: counter SHALL count down from latched run_cycles once per cycle; cpu_hold=0; on reaching 0 go to HOLD.
REQ-009 run_cycles=0 SHALL go RUN->HOLD after exactly one RUN cycle.
REQ-010 HOLD: cpu_hold=1 for one cycle to let an in-flight memory write retire, then READ with index 0.
REQ-011 READ: rd_addr SHALL equal table[idx].addr; next state CMP.
REQ-012 CMP: mismatch when (rd_data ^ exp) & mask != 0 (mask all-ones without macro); mismatch increments err_count; first mismatch captures idx and rd_data.
REQ-013 CMP: if idx == latched cfg_num-1 go DONE, else idx+1 and READ; each check costs exactly 2 cycles.
REQ-014 cfg_num=0 SHALL skip READ/CMP: HOLD->DONE, pass=1, err_count=0.
REQ-015 cfg_num>NCHK SHALL be saturated to NCHK at latch.
REQ-016 DONE: done=1 for one cycle, pass=(err_count==0), then IDLE; cpu_hold SHALL remain 1 in DONE and IDLE after a completed run until next start.
REQ-017 busy SHALL be 1 in RUN, HOLD, READ, CMP; 0 in IDLE, DONE.
REQ-018 start while busy SHALL be ignored.
REQ-019 cfg_we SHALL write the table in any state; writes while busy take effect for entries not yet read.
REQ-020 Simultaneous cfg_we and start SHALL write the table and start; written entry visible to the run.
REQ-021 rd_addr SHALL hold its last value outside READ.

Reset
REQ-022 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_actual=0, rd_addr=0, cpu_hold=0.
REQ-023 Reset SHALL NOT clear the check table (memory content undefined until written).
REQ-024 Reset mid-run SHALL abort without a done pulse.

Configuration
REQ-025 MEM_CHECKER_MASK_EN defined: per-entry cfg_mask port and mask storage exist and apply in REQ-012.
REQ-026 MEM_CHECKER_MASK_EN undefined: no cfg_mask port, no mask storage, full-word compare.

Verification
REQ-027 Table {256:472, 300:10, 401:21, 402:22, 3006:36, 3012:42, 3015:45, 11:510}, memory matching, run_cycles=332, start -> done at cycle 332+1+1+16+1 after start, pass=1, err_count=0.
REQ-028 Same but mem[3012]=41 -> pass=0, err_count=1, first_err_idx=5, first_err_actual=41.
REQ-029 cfg_num=0, run_cycles=0 -> done 3 cycles after start, pass=1; cpu_hold=1 from HOLD onward.
REQ-030 reset_n low during READ of entry 3 -> all outputs zero same cycle, no done; restart completes normally.
REQ-031 MASK_EN: entry {11, exp 0x01FE, mask 0x00FF}, mem[11]=0xFFFE -> pass=1; mask 0xFFFF -> pass=0.
REQ-032 start pulse during RUN -> ignored; done timing unchanged.
